multi_digit_led_driver: RTL and testbench
=========================================

MULTI_DIGIT_LED_DRIVER -- requirements
Module: multi_digit_led_driver

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DIGITS, 4, number of 7-segment digits, 1..8.
- DATA_W, 14, binary input width, 4..32.
- SCAN_DIV, 1000, clk cycles per digit scan slot, >=2.
- ACTIVE_LOW, 0, 1 inverts seg_out and digit_sel.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- value_in, in, DATA_W, unsigned binary value to display.
- load, in, 1, conversion request strobe.
- blank_lz, in, 1, leading-zero blanking enable.
- busy, out, 1, conversion in progress.
- done, out, 1, one-cycle pulse, new value visible.
- ovf, out, 1, last committed value exceeded 10^DIGITS-1.
- seg_out, out, 7, segments a..g, bit6=a, bit0=g.
- digit_sel, out, DIGITS, one-hot digit enable, bit0 = least significant digit.

Function
REQ-003 The FSM SHALL have three states: IDLE, CONVERT and COMMIT.
REQ-004 In IDLE, load=1 SHALL capture value_in and blank_lz, clear the step counter, and enter CONVERT.
REQ-005 CONVERT SHALL perform one sequential double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift left one bit); after DATA_W steps it SHALL enter COMMIT.
REQ-006 COMMIT SHALL write the display digit registers in a single cycle and return to IDLE.
REQ-007 busy SHALL be high on the cycle after load is accepted and SHALL stay high for exactly DATA_W+1 cycles.
REQ-008 done SHALL go high for exactly one cycle, on the first cycle the new digits are visible; busy SHALL be 0 on that cycle.
REQ-009 load while busy=1 SHALL be ignored with no queueing; load on the done cycle SHALL be accepted.
REQ-010 During conversion the display SHALL keep showing the previously committed value.
REQ-011 If the captured value >= 10^DIGITS, COMMIT SHALL set ovf=1 and store the dash code (0xE) in every digit; otherwise ovf SHALL be 0.
REQ-012 When blank_lz=1 and there is no overflow, zero digits above the most significant non-zero digit SHALL get the blank code (0xF); digit 0 SHALL never be blanked.
REQ-013 Digit code-to-segment mapping (abcdefg), before polarity inversion:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011
- 0xE=0000001; 0xF and every other code=0000000.
REQ-014 A prescaler SHALL count 0..SCAN_DIV-1 and wrap. On each wrap the digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-015 seg_out and digit_sel SHALL be registered and SHALL update on the same edge; seg_out SHALL show the digit currently selected, with 1 cycle of latency from the index change.
REQ-016 ACTIVE_LOW=1 SHALL bitwise-invert seg_out and digit_sel at the output register only.
REQ-017 Scanning SHALL run continuously and independently of the FSM state.

Reset
REQ-018 While rst=1, asynchronously:
- FSM=IDLE, busy=0, done=0, ovf=0.
- prescaler=0, digit index=0.
- all display digits=0xF.
- seg_out=0000000, digit_sel=one-hot bit0, both polarity-adjusted.
REQ-019 rst asserted mid-conversion SHALL abort the conversion; the value in flight SHALL never be committed.
REQ-020 After rst deasserts, the first load SHALL be accepted on the first clk edge.

Verification (DIGITS=4, DATA_W=14, SCAN_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-021 load value_in=1234, blank_lz=0 -> busy high 15 cycles; then done pulse; then per slot digit_sel 0001/seg 0110011, 0010/1111001, 0100/1101101, 1000/0110000.
REQ-022 load 7, blank_lz=1 -> digit0 shows 1110010; digits 1-3 show 0000000; ovf=0.
REQ-023 load 10000 -> ovf=1; all four digits show 0000001; then load 9999 -> ovf=0; all digits show 1111011.
REQ-024 load 42, then load 99 on busy cycle 5 -> 99 ignored, 42 committed; load 99 on the done cycle -> accepted, busy rises on the next cycle.
REQ-025 rst pulse on CONVERT step 6 of load 5555 -> all outputs at reset values; no done pulse; display stays blank.
REQ-026 Idle scan -> digit_sel 0001,0010,0100,1000,0001, each held 4 cycles; with ACTIVE_LOW=1 -> 1110,1101,1011,0111, and seg_out inverted.

Source files
------------

// File: rtl/multi_digit_led_driver.sv
// Multiplexed 7-segment driver: converts a binary value to BCD with a
// sequential double-dabble FSM and scans the committed digits one per slot.
module multi_digit_led_driver #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value_in,
    input  logic              load,
    input  logic              blank_lz,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [6:0]        seg_out,
    output logic [DIGITS-1:0] digit_sel
);

    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PRE_W   = $clog2(SCAN_DIV);
    localparam int unsigned STEP_W  = $clog2(DATA_W);
    // Enough BCD nibbles for 2^DATA_W-1, and never fewer than the display width.
    localparam int unsigned BCD_MIN = (DATA_W * 3) / 10 + 2;
    localparam int unsigned BCD_N   = (DIGITS > BCD_MIN) ? DIGITS : BCD_MIN;
    localparam int unsigned DD_W    = 4 * BCD_N + DATA_W;
    localparam logic        POL     = (ACTIVE_LOW != 0);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110010;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1111011;
            4'hE:    s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StCommit
    } state_e;

    state_e              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    // {bcd nibbles, binary remainder} shifted together by double-dabble.
    logic [DD_W-1:0]     dd_q, dd_d, dd_adj;
    logic                blank_q, blank_d;
    logic                ovf_cap_q, ovf_cap_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
    logic [3:0]          digit_q [DIGITS];
    logic [3:0]          digit_d [DIGITS];
    logic [3:0]          commit_code [DIGITS];
    logic                lead;
    logic [3:0]          nib;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign ovf  = ovf_q;

    // Add-3 correction of every BCD nibble that is 5 or more.
    always_comb begin
        dd_adj = dd_q;
        for (int unsigned i = 0; i < BCD_N; i++) begin
            if (dd_q[DATA_W + 4*i +: 4] >= 4'd5) begin
                dd_adj[DATA_W + 4*i +: 4] = dd_q[DATA_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Display codes produced at commit: dashes on overflow, else digits with
    // optional leading-zero blanking scanned from the top digit down.
    always_comb begin
        lead = blank_q;
        nib  = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            commit_code[i] = 4'hF;
        end
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nib = dd_q[DATA_W + 4*i +: 4];
            if (ovf_cap_q) begin
                commit_code[i] = 4'hE;
            end else if (lead && (i != 0) && (nib == 4'd0)) begin
                commit_code[i] = 4'hF;
            end else begin
                commit_code[i] = nib;
                lead = 1'b0;
            end
        end
    end

    // Conversion FSM next-state logic.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        dd_d      = dd_q;
        blank_d   = blank_q;
        ovf_cap_d = ovf_cap_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        digit_d   = digit_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    dd_d      = {{(4*BCD_N){1'b0}}, value_in};
                    blank_d   = blank_lz;
                    ovf_cap_d = (64'(value_in) >= OVF_LIMIT);
                    step_d    = '0;
                    state_d   = StConvert;
                end
            end
            StConvert: begin
                dd_d   = dd_adj << 1;
                step_d = step_q + 1'b1;
                if (step_q == STEP_W'(DATA_W - 1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                digit_d = commit_code;
                ovf_d   = ovf_cap_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Conversion FSM and display digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= '0;
            dd_q      <= '0;
            blank_q   <= 1'b0;
            ovf_cap_q <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                digit_q[i] <= 4'hF;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            dd_q      <= dd_d;
            blank_q   <= blank_d;
            ovf_cap_q <= ovf_cap_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            digit_q   <= digit_d;
        end
    end

    // Scan prescaler and digit index advance, free-running.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Scan counters plus the polarity-adjusted output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= '0;
            seg_out   <= {7{POL}};
            digit_sel <= DIGITS'(1) ^ {DIGITS{POL}};
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_out   <= seg7(digit_q[idx_q]) ^ {7{POL}};
            digit_sel <= (DIGITS'(1) << idx_q) ^ {DIGITS{POL}};
        end
    end

endmodule

// File: tb/tb_multi_digit_led_driver.sv
// Bench for multi_digit_led_driver: an active-high and an active-low instance
// share stimulus and are checked against a decimal-arithmetic display model.
module tb_multi_digit_led_driver;

    localparam int DIGITS   = 4;
    localparam int DATA_W   = 14;
    localparam int SCAN_DIV = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] value_in = '0;
    logic              load = 1'b0;
    logic              blank_lz = 1'b0;
    logic              busy, done, ovf;
    logic [6:0]        seg_out;
    logic [DIGITS-1:0] digit_sel;
    logic              busy_n, done_n, ovf_n;
    logic [6:0]        seg_out_n;
    logic [DIGITS-1:0] digit_sel_n;

    multi_digit_led_driver #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .blank_lz(blank_lz),
        .busy(busy), .done(done), .ovf(ovf), .seg_out(seg_out), .digit_sel(digit_sel)
    );

    multi_digit_led_driver #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1)
    ) dut_n (
        .clk(clk), .rst(rst), .value_in(value_in), .load(load), .blank_lz(blank_lz),
        .busy(busy_n), .done(done_n), .ovf(ovf_n), .seg_out(seg_out_n),
        .digit_sel(digit_sel_n)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset; drives the expected scan position.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int errors = 0;
    int checks = 0;

    // Model of the committed display contents and overflow flag.
    int   codes [DIGITS];
    logic ovf_exp;

    // Samples collected by capture().
    int         s_cyc  [64];
    logic       s_done [64];
    logic [6:0] s_seg  [64];
    logic [6:0] s_segn [64];
    logic [3:0] s_sel  [64];
    logic [3:0] s_seln [64];

    function automatic logic [6:0] seg_model(input int code);
        case (code)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110010;
            8: return 7'b1111111;
            9: return 7'b1111011;
            14: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    // Display contents from the decimal value: dashes past 10^DIGITS-1,
    // otherwise decimal digits, blanking positions above the value's magnitude.
    function automatic void model_commit(input int v, input bit b);
        int p;
        p = 1;
        for (int i = 0; i < DIGITS; i++) p = p * 10;
        ovf_exp = (v >= p);
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_exp)                     codes[i] = 14;
            else if (b && i > 0 && v < p)    codes[i] = 15;
            else                             codes[i] = (v / p) % 10;
            p = p * 10;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DIGITS; i++) codes[i] = 15;
        ovf_exp = 1'b0;
    endfunction

    // Digit shown by the output register after edge k of the scan.
    function automatic int exp_idx(input int k);
        return (k == 0) ? 0 : ((k - 1) / SCAN_DIV) % DIGITS;
    endfunction

    task automatic capture(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            s_cyc[j]  = cyc;
            s_done[j] = done;
            s_seg[j]  = seg_out;
            s_segn[j] = seg_out_n;
            s_sel[j]  = digit_sel;
            s_seln[j] = digit_sel_n;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_load(input int v, input bit b);
        value_in = DATA_W'(v);
        blank_lz = b;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Counts busy samples until done is seen, bounded at 40 cycles.
    task automatic wait_done(output int nbusy, output bit got, output logic busy_at);
        nbusy   = 0;
        got     = 1'b0;
        busy_at = 1'bx;
        for (int t = 0; t < 40 && !got; t++) begin
            if (done === 1'b1) begin
                got     = 1'b1;
                busy_at = busy;
            end else begin
                if (busy === 1'b1) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, ovf, seg_out, digit_sel} !== {3'b000, 7'b0000000, 4'b0001}) begin
            errors++;
            $display("FAIL reset_hi: busy/done/ovf/seg/sel=%b%b%b/%b/%b required 000/0000000/0001",
                     busy, done, ovf, seg_out, digit_sel);
        end
        checks++;
        if ({busy_n, done_n, ovf_n, seg_out_n, digit_sel_n} !== {3'b000, 7'b1111111, 4'b1110})
        begin
            errors++;
            $display("FAIL reset_lo: busy/done/ovf/seg/sel=%b%b%b/%b/%b required 000/1111111/1110",
                     busy_n, done_n, ovf_n, seg_out_n, digit_sel_n);
        end
        rst = 1'b0;
        capture(20);
        for (int j = 0; j < 20; j++) begin
            e_sel = 4'(1 << exp_idx(s_cyc[j]));
            e_seg = seg_model(codes[exp_idx(s_cyc[j])]);
            checks++;
            if ({s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j]} !==
                {1'b0, e_seg, e_sel, ~e_seg, ~e_sel}) begin
                errors++;
                $display("FAIL idle_scan[%0d]: done=%b seg=%b sel=%b segn=%b seln=%b required seg=%b sel=%b",
                         j, s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j], e_seg, e_sel);
            end
        end
    endtask

    // Loads a value, checks the busy window, done pulse and ovf, then the scan.
    task automatic test_value(input string name, input int v, input bit b);
        int nb;
        bit got;
        logic ba;
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        start_load(v, b);
        wait_done(nb, got, ba);
        checks++;
        if (!(got && nb == DATA_W + 1 && ba === 1'b0)) begin
            errors++;
            $display("FAIL %s busy_done: done_seen=%0d busy_cycles=%0d busy_on_done=%b required 1/%0d/0",
                     name, got, nb, ba, DATA_W + 1);
        end
        model_commit(v, b);
        checks++;
        if (ovf !== ovf_exp || ovf_n !== ovf_exp) begin
            errors++;
            $display("FAIL %s ovf: got %b/%b required %b", name, ovf, ovf_n, ovf_exp);
        end
        capture(16);
        for (int j = 0; j < 16; j++) begin
            e_sel = 4'(1 << exp_idx(s_cyc[j]));
            e_seg = seg_model(codes[exp_idx(s_cyc[j])]);
            checks++;
            if ({s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j]} !==
                {1'b0, e_seg, e_sel, ~e_seg, ~e_sel}) begin
                errors++;
                $display("FAIL %s scan[%0d]: done=%b seg=%b sel=%b segn=%b seln=%b required seg=%b sel=%b",
                         name, j, s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j], e_seg, e_sel);
            end
        end
    endtask

    task automatic test_first_load();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        value_in = DATA_W'(0);
        start_load(0, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_load: busy=%b required 1", busy);
        end
        // Drain this conversion, then confirm zero with blanking shows a lone 0.
        repeat (DATA_W + 1) @(negedge clk);
        test_value("zero_blank", 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int nb;
        bit got;
        logic ba;
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        start_load(42, 1'b0);
        repeat (4) @(negedge clk);
        value_in = DATA_W'(99);
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        wait_done(nb, got, ba);
        checks++;
        if (!(got && nb == DATA_W + 1 - 5 && ba === 1'b0)) begin
            errors++;
            $display("FAIL b2b_ignore: done_seen=%0d busy_cycles=%0d busy_on_done=%b required 1/%0d/0",
                     got, nb, ba, DATA_W + 1 - 5);
        end
        model_commit(42, 1'b0);
        // Load on the done cycle must be taken straight away.
        value_in = DATA_W'(99);
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_load: busy=%b required 1", busy);
        end
        // While 99 converts the display must still show 42.
        capture(12);
        for (int j = 0; j < 12; j++) begin
            e_sel = 4'(1 << exp_idx(s_cyc[j]));
            e_seg = seg_model(codes[exp_idx(s_cyc[j])]);
            checks++;
            if ({s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j]} !==
                {1'b0, e_seg, e_sel, ~e_seg, ~e_sel}) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: done=%b seg=%b sel=%b segn=%b seln=%b required seg=%b sel=%b",
                         j, s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j], e_seg, e_sel);
            end
        end
        wait_done(nb, got, ba);
        checks++;
        if (!(got && ba === 1'b0)) begin
            errors++;
            $display("FAIL b2b_second_done: done_seen=%0d busy_on_done=%b required 1/0", got, ba);
        end
        model_commit(99, 1'b0);
        capture(16);
        for (int j = 0; j < 16; j++) begin
            e_sel = 4'(1 << exp_idx(s_cyc[j]));
            e_seg = seg_model(codes[exp_idx(s_cyc[j])]);
            checks++;
            if ({s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j]} !==
                {1'b0, e_seg, e_sel, ~e_seg, ~e_sel}) begin
                errors++;
                $display("FAIL b2b_99[%0d]: done=%b seg=%b sel=%b segn=%b seln=%b required seg=%b sel=%b",
                         j, s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j], e_seg, e_sel);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] e_sel;
        logic [6:0] e_seg;
        start_load(5555, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, ovf, seg_out, digit_sel, busy_n, done_n, ovf_n, seg_out_n, digit_sel_n}
            !== {3'b000, 7'b0000000, 4'b0001, 3'b000, 7'b1111111, 4'b1110}) begin
            errors++;
            $display("FAIL abort_reset: hi=%b%b%b/%b/%b lo=%b%b%b/%b/%b required 000/0000000/0001 000/1111111/1110",
                     busy, done, ovf, seg_out, digit_sel, busy_n, done_n, ovf_n, seg_out_n, digit_sel_n);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        capture(32);
        for (int j = 0; j < 32; j++) begin
            e_sel = 4'(1 << exp_idx(s_cyc[j]));
            e_seg = seg_model(codes[exp_idx(s_cyc[j])]);
            checks++;
            if ({s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j]} !==
                {1'b0, e_seg, e_sel, ~e_seg, ~e_sel}) begin
                errors++;
                $display("FAIL abort_blank[%0d]: done=%b seg=%b sel=%b segn=%b seln=%b required seg=%b sel=%b",
                         j, s_done[j], s_seg[j], s_sel[j], s_segn[j], s_seln[j], e_seg, e_sel);
            end
        end
        checks++;
        if (busy !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b ovf=%b required 0/0", busy, ovf);
        end
    endtask

    task automatic test_random();
        int v;
        bit b;
        for (int n = 0; n < 8; n++) begin
            v = int'($urandom_range(16383, 0));
            b = 1'($urandom_range(1, 0));
            test_value("random", v, b);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_value("v1234", 1234, 1'b0);
        test_value("v7_blank", 7, 1'b1);
        test_value("v10000_ovf", 10000, 1'b0);
        test_value("v9999", 9999, 1'b0);
        test_value("v1000_blank", 1000, 1'b1);
        test_value("v16383_ovf_blank", 16383, 1'b1);
        test_back_to_back();
        test_random();
        test_first_load();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
